mem_bus_target: RTL and testbench
=================================

# mem_bus_target

Bus-side memory responder for the cpu8080 core. It decodes the core's multiplexed-free address/strobe bus (ADD, RDn, WRn, IO_Mn), serves reads and writes from an internal synchronous RAM, and paces the core through READY with a parameterised number of wait states. It sits directly downstream of the CPU: it consumes the core's bus cycles and drives DATA and READY back to it.

## Interface
- ADDR_W, 10: RAM address width; depth 2^ADDR_W bytes.
- BASE, 16'h0000: window base; hit when ADD[15:ADDR_W] == BASE[15:ADDR_W]. Must be aligned to 2^ADDR_W.
- WAIT_CYCLES, 1: wait states per access, 0..15.

- clock  in  1  single clock; all state updates on the rising edge, since the CPU updates on the falling edge.
- reset_in  in  1  synchronous, active-high reset.
- ADD  in  16  CPU address.
- DATA  inout  8  CPU data bus; driven only as stated below, else 8'bzzzzzzzz.
- IO_Mn  in  1  0 = memory cycle, 1 = I/O cycle.
- RDn  in  1  read strobe, active low.
- WRn  in  1  write strobe, active low.
- READY  out  1  0 inserts CPU wait states.
- io_port_out  out  8  last I/O write value; 8'h00 when MEM_IO_PORT_EN is absent.
- io_strobe  out  1  one-cycle pulse on each I/O write; constant 0 when the macro is absent.

## Operation
- FSM states: IDLE, WAIT, RD_DRIVE, WR_COMMIT, HOLD.
- Access detect (IDLE, rising edge):
  - Memory read: hit & IO_Mn=0 & RDn=0 & WRn=1.
  - Memory write: same, with WRn=0 & RDn=1.
  - The address is latched into addr_q. The wait counter loads WAIT_CYCLES.
  - If WAIT_CYCLES>0, READY<=0 and the FSM goes to WAIT. Otherwise it goes directly to RD_DRIVE or WR_COMMIT.
- WAIT: counter decrements each edge. At 1, READY<=1 and the FSM goes to RD_DRIVE or WR_COMMIT.
- RD_DRIVE: data_q<=mem[addr_q], then HOLD. DATA is driven from data_q while state is RD_DRIVE or HOLD and RDn=0.
- WR_COMMIT: mem[addr_q]<=DATA sampled on this edge, then HOLD.
- HOLD: remain until both RDn and WRn are high, then IDLE. Exactly one RAM write per WRn-low period.
- Boundary conditions:
  - Miss, or RDn=WRn=0: ignored. FSM stays IDLE, READY=1, DATA hi-Z.
  - Strobe released during WAIT: abort to IDLE, READY<=1, no RAM write.
  - ADD changing after detect: no effect; addr_q is used.
  - addr_q wraps modulo 2^ADDR_W; only ADD[ADDR_W-1:0] indexes the RAM.
  - Reset mid-access: state IDLE, READY=1, DATA released, counter 0. RAM contents are preserved, not cleared.
- Reset values: READY=1, DATA=hi-Z, io_port_out=8'h00, io_strobe=0.

## Timing
- Detect edge = first rising edge with the strobe low.
- Read data is valid on DATA from detect edge + WAIT_CYCLES + 1, and held until RDn rises.
- READY is low for exactly WAIT_CYCLES rising edges, starting at the detect edge.
- With WAIT_CYCLES=0, READY never drops.
- The CPU samples READY/DATA on the falling edge following the edge at which they update (half-cycle setup).
- Back-to-back accesses: a new access needs one IDLE edge after both strobes are high.

## Configuration
- MEM_IO_PORT_EN defined:
  - An I/O write (IO_Mn=1, WRn=0, ADD[7:0]==8'h00) follows the same wait/commit flow.
  - It latches DATA into io_port_out and pulses io_strobe for one cycle in WR_COMMIT.
  - An I/O read of port 8'h00 returns io_port_out.
- MEM_IO_PORT_EN undefined: all IO_Mn=1 cycles are treated as misses; io outputs are tied to 0.

## Structure
- bus_pkg:
  - state enum mem_tgt_state_t.
  - WAIT_CNT_W=4.
  - IO port address constant IO_PORT0=8'h00.
- Sub-module mem_bus_ram: single-port synchronous RAM (ADDR_W, 8-bit), registered read, write-enable. Contents are undefined after power-up and untouched by reset.

## Test plan
- WAIT_CYCLES=0, write 8'hA5 to 16'h0010, then read it back -> READY stays 1; DATA=8'hA5 from detect+1 until RDn rises.
- WAIT_CYCLES=3, read 16'h0010 -> READY low for exactly 3 edges; data valid at detect+4.
- Read 16'h8000 with BASE=0, ADDR_W=10 -> DATA hi-Z, READY=1, FSM stays IDLE.
- WRn released during WAIT (WAIT_CYCLES=5) -> abort to IDLE; a later read returns the old byte.
- reset_in asserted in HOLD during a read -> next edge: IDLE, READY=1, DATA hi-Z; prior RAM contents intact.
- MEM_IO_PORT_EN: I/O write 8'h3C to port 0 -> io_port_out=8'h3C, one io_strobe pulse; without the macro -> io_port_out=0, no pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the cpu8080 memory bus target.
package bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRdDrive,
    StWrCommit,
    StHold
  } mem_tgt_state_t;

  localparam int unsigned WAIT_CNT_W = 4;
  localparam logic [7:0]  IO_PORT0   = 8'h00;

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous byte RAM with registered read; contents are never reset.
module mem_bus_ram #(
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_bus_target.sv
// Memory responder for the cpu8080 bus: decodes strobes, paces the core via READY.
// Optional I/O port 0 register enabled by defining MEM_IO_PORT_EN.
module mem_bus_target
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [15:0] BASE        = 16'h0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic [15:0] ADD,
  inout  wire  [7:0]  DATA,
  input  logic        IO_Mn,
  input  logic        RDn,
  input  logic        WRn,
  output logic        READY,
  output logic [7:0]  io_port_out,
  output logic        io_strobe
);

  localparam logic [WAIT_CNT_W-1:0] WaitInit = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CntOne   = WAIT_CNT_W'(1);

  mem_tgt_state_t        state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  is_wr_q, is_wr_d;
  logic                  is_io_q, is_io_d;

  logic       mem_hit, io_hit, rd_req, wr_req, start;
  logic       ram_we, ram_re, drive_en;
  logic [7:0] ram_rdata, rd_data;

  assign mem_hit = !IO_Mn && (ADD[15:ADDR_W] == BASE[15:ADDR_W]);
`ifdef MEM_IO_PORT_EN
  assign io_hit  = IO_Mn && (ADD[7:0] == IO_PORT0);
`else
  assign io_hit  = 1'b0;
`endif
  // Both strobes low at once is not a legal cycle and is ignored.
  assign rd_req = !RDn && WRn;
  assign wr_req = !WRn && RDn;
  assign start  = (mem_hit || io_hit) && (rd_req || wr_req);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    is_wr_d = is_wr_q;
    is_io_d = is_io_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = ADD[ADDR_W-1:0];
          cnt_d   = WaitInit;
          is_wr_d = wr_req;
          is_io_d = io_hit;
          if (WAIT_CYCLES > 0) begin
            ready_d = 1'b0;
            state_d = StWait;
          end else begin
            state_d = wr_req ? StWrCommit : StRdDrive;
          end
        end
      end
      StWait: begin
        // Releasing the strobe of the latched cycle abandons the access.
        if (is_wr_q ? WRn : RDn) begin
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            ready_d = 1'b1;
            state_d = is_wr_q ? StWrCommit : StRdDrive;
          end
        end
      end
      StRdDrive, StWrCommit: state_d = StHold;
      StHold: begin
        if (RDn && WRn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_in) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      is_wr_q <= 1'b0;
      is_io_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      is_wr_q <= is_wr_d;
      is_io_q <= is_io_d;
    end
  end

  assign ram_we = (state_q == StWrCommit) && !is_io_q;
  assign ram_re = (state_q == StRdDrive) && !is_io_q;

  mem_bus_ram #(
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (clock),
    .addr_i  (addr_q),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .wdata_i (DATA),
    .rdata_o (ram_rdata)
  );

`ifdef MEM_IO_PORT_EN
  logic [7:0] io_port_q;

  always_ff @(posedge clock) begin
    if (reset_in) begin
      io_port_q <= 8'h00;
    end else if ((state_q == StWrCommit) && is_io_q) begin
      io_port_q <= DATA;
    end
  end

  assign io_port_out = io_port_q;
  assign io_strobe   = (state_q == StWrCommit) && is_io_q;
`else
  assign io_port_out = 8'h00;
  assign io_strobe   = 1'b0;
`endif

  assign rd_data  = is_io_q ? io_port_out : ram_rdata;
  assign drive_en = ((state_q == StRdDrive) || (state_q == StHold)) && !is_wr_q && !RDn;
  assign DATA     = drive_en ? rd_data : 8'bzzzzzzzz;
  assign READY    = ready_q;

endmodule

// File: tb/tb_mem_bus_target.sv
// Directed bench for mem_bus_target: three instances with 0, 3 and 5 wait states.
module tb_mem_bus_target;

`ifdef MEM_IO_PORT_EN
  localparam bit IoEn = 1'b1;
`else
  localparam bit IoEn = 1'b0;
`endif
  // The bench drives this on DATA to see whether the target is also driving.
  localparam logic [7:0] Probe = 8'h5A;

  logic        clock = 1'b0;
  logic        reset_in;
  logic [15:0] ADD;
  logic        IO_Mn;
  logic [2:0]  rdn, wrn, drv_en;
  logic [7:0]  drv_val;
  wire  [7:0]  d0, d1, d2, iop0, iop1, iop2;
  wire  [2:0]  ready, ios;
  wire  [23:0] dall = {d2, d1, d0};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  assign d0 = drv_en[0] ? drv_val : 8'bzzzzzzzz;
  assign d1 = drv_en[1] ? drv_val : 8'bzzzzzzzz;
  assign d2 = drv_en[2] ? drv_val : 8'bzzzzzzzz;

  mem_bus_target #(.ADDR_W(10), .BASE(16'h0000), .WAIT_CYCLES(0)) u0 (
    .clock(clock), .reset_in(reset_in), .ADD(ADD), .DATA(d0), .IO_Mn(IO_Mn), .RDn(rdn[0]),
    .WRn(wrn[0]), .READY(ready[0]), .io_port_out(iop0), .io_strobe(ios[0]));
  mem_bus_target #(.ADDR_W(10), .BASE(16'h0000), .WAIT_CYCLES(3)) u3 (
    .clock(clock), .reset_in(reset_in), .ADD(ADD), .DATA(d1), .IO_Mn(IO_Mn), .RDn(rdn[1]),
    .WRn(wrn[1]), .READY(ready[1]), .io_port_out(iop1), .io_strobe(ios[1]));
  mem_bus_target #(.ADDR_W(10), .BASE(16'h0000), .WAIT_CYCLES(5)) u5 (
    .clock(clock), .reset_in(reset_in), .ADD(ADD), .DATA(d2), .IO_Mn(IO_Mn), .RDn(rdn[2]),
    .WRn(wrn[2]), .READY(ready[2]), .io_port_out(iop2), .io_strobe(ios[2]));

  task automatic probe(input int k, output logic [7:0] v);
    drv_val   = Probe;
    drv_en[k] = 1'b1;
    #1 v = dall[k*8 +: 8];
    drv_en[k] = 1'b0;
    #1;
  endtask

  task automatic wr(input int k, input logic [15:0] a, input logic [7:0] v, input logic io,
                    output int low);
    @(negedge clock);
    ADD = a; IO_Mn = io; drv_val = v; drv_en[k] = 1'b1; wrn[k] = 1'b0;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ready[k] === 1'b0) low++;
      else break;
    end
    @(negedge clock);
    wrn[k] = 1'b1; drv_en[k] = 1'b0; IO_Mn = 1'b0;
    @(negedge clock);
  endtask

  task automatic rd(input int k, input logic [15:0] a, input logic io, input logic [15:0] a_after,
                    output int low, output logic [7:0] df, output logic [7:0] dh,
                    output logic [7:0] dr);
    @(negedge clock);
    ADD = a; IO_Mn = io; rdn[k] = 1'b0;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      ADD = a_after;
      if (ready[k] === 1'b0) low++;
      else break;
    end
    @(negedge clock);
    df = dall[k*8 +: 8];
    @(negedge clock);
    dh = dall[k*8 +: 8];
    rdn[k] = 1'b1;
    probe(k, dr);
    IO_Mn = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    n_cmp++; if (ready !== 3'b111) begin n_bad++; $display("FAIL reset_ready: got %b want 111", ready); end
    for (int k = 0; k < 3; k++) begin
      probe(k, v);
      n_cmp++; if (v !== Probe) begin n_bad++; $display("FAIL reset_data[%0d]: got %h want %h", k, v, Probe); end
    end
    n_cmp++; if (iop0 !== 8'h00) begin n_bad++; $display("FAIL reset_io_port: got %h want 00", iop0); end
    n_cmp++; if (ios !== 3'b000) begin n_bad++; $display("FAIL reset_io_strobe: got %b want 000", ios); end
  endtask

  task automatic test_zero_wait();
    int low; logic [7:0] df, dh, dr;
    wr(0, 16'h0010, 8'hA5, 1'b0, low);
    n_cmp++; if (low !== 0) begin n_bad++; $display("FAIL w0_write_ready_low: got %0d want 0", low); end
    rd(0, 16'h0010, 1'b0, 16'h0010, low, df, dh, dr);
    n_cmp++; if (low !== 0) begin n_bad++; $display("FAIL w0_read_ready_low: got %0d want 0", low); end
    n_cmp++; if (df !== 8'hA5) begin n_bad++; $display("FAIL w0_read_first: got %h want a5", df); end
    n_cmp++; if (dh !== 8'hA5) begin n_bad++; $display("FAIL w0_read_held: got %h want a5", dh); end
    n_cmp++; if (dr !== Probe) begin n_bad++; $display("FAIL w0_read_release: got %h want %h", dr, Probe); end
  endtask

  task automatic test_wait3();
    int low; logic [7:0] df, dh, dr;
    wr(1, 16'h0010, 8'hA5, 1'b0, low);
    n_cmp++; if (low !== 3) begin n_bad++; $display("FAIL w3_write_ready_low: got %0d want 3", low); end
    wr(1, 16'h0011, 8'h77, 1'b0, low);
    // ADD moves to 0x0011 right after detect; the latched 0x0010 must be used.
    rd(1, 16'h0010, 1'b0, 16'h0011, low, df, dh, dr);
    n_cmp++; if (low !== 3) begin n_bad++; $display("FAIL w3_read_ready_low: got %0d want 3", low); end
    n_cmp++; if (df !== 8'hA5) begin n_bad++; $display("FAIL w3_read_first: got %h want a5", df); end
    rd(1, 16'h0011, 1'b0, 16'h0011, low, df, dh, dr);
    n_cmp++; if (df !== 8'h77) begin n_bad++; $display("FAIL w3_read_second: got %h want 77", df); end
  endtask

  task automatic test_miss();
    int low; logic [7:0] v, df, dh, dr;
    @(negedge clock);
    ADD = 16'h8000; IO_Mn = 1'b0; rdn[0] = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (ready[0] !== 1'b1) begin n_bad++; $display("FAIL miss_ready: got %b want 1", ready[0]); end
    probe(0, v);
    n_cmp++; if (v !== Probe) begin n_bad++; $display("FAIL miss_data: got %h want %h", v, Probe); end
    rdn[0] = 1'b1;
    // Both strobes low together is ignored as well.
    @(negedge clock);
    ADD = 16'h0010; rdn[0] = 1'b0; wrn[0] = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (ready[0] !== 1'b1) begin n_bad++; $display("FAIL both_low_ready: got %b want 1", ready[0]); end
    probe(0, v);
    n_cmp++; if (v !== Probe) begin n_bad++; $display("FAIL both_low_data: got %h want %h", v, Probe); end
    rdn[0] = 1'b1; wrn[0] = 1'b1;
    rd(0, 16'h0010, 1'b0, 16'h0010, low, df, dh, dr);
    n_cmp++; if (df !== 8'hA5) begin n_bad++; $display("FAIL after_miss_read: got %h want a5", df); end
  endtask

  task automatic test_abort();
    int low; logic [7:0] df, dh, dr;
    wr(2, 16'h0020, 8'h11, 1'b0, low);
    n_cmp++; if (low !== 5) begin n_bad++; $display("FAIL w5_write_ready_low: got %0d want 5", low); end
    @(negedge clock);
    ADD = 16'h0020; IO_Mn = 1'b0; drv_val = 8'h99; drv_en[2] = 1'b1; wrn[2] = 1'b0;
    repeat (2) @(negedge clock);
    wrn[2] = 1'b1; drv_en[2] = 1'b0;
    @(negedge clock);
    n_cmp++; if (ready[2] !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", ready[2]); end
    rd(2, 16'h0020, 1'b0, 16'h0020, low, df, dh, dr);
    n_cmp++; if (low !== 5) begin n_bad++; $display("FAIL w5_read_ready_low: got %0d want 5", low); end
    n_cmp++; if (df !== 8'h11) begin n_bad++; $display("FAIL abort_old_byte: got %h want 11", df); end
  endtask

  task automatic test_io();
    int low, cnt; logic [7:0] v, df, dh, dr;
    wr(0, 16'h0000, 8'hC3, 1'b0, low);
    @(negedge clock);
    ADD = 16'h0000; IO_Mn = 1'b1; drv_val = 8'h3C; drv_en[0] = 1'b1; wrn[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (ios[0] === 1'b1) cnt++;
      if (i == 1) begin wrn[0] = 1'b1; drv_en[0] = 1'b0; end
    end
    IO_Mn = 1'b0;
    n_cmp++; if (cnt !== (IoEn ? 1 : 0)) begin n_bad++; $display("FAIL io_strobe_pulses: got %0d want %0d", cnt, IoEn ? 1 : 0); end
    n_cmp++; if (iop0 !== (IoEn ? 8'h3C : 8'h00)) begin n_bad++; $display("FAIL io_port_out: got %h want %h", iop0, IoEn ? 8'h3C : 8'h00); end
`ifdef MEM_IO_PORT_EN
    rd(0, 16'h0000, 1'b1, 16'h0000, low, df, dh, dr);
    n_cmp++; if (df !== 8'h3C) begin n_bad++; $display("FAIL io_read: got %h want 3c", df); end
`else
    @(negedge clock);
    ADD = 16'h0000; IO_Mn = 1'b1; rdn[0] = 1'b0;
    repeat (2) @(negedge clock);
    probe(0, v);
    n_cmp++; if (v !== Probe) begin n_bad++; $display("FAIL io_read_miss: got %h want %h", v, Probe); end
    rdn[0] = 1'b1; IO_Mn = 1'b0;
`endif
    rd(0, 16'h0000, 1'b0, 16'h0000, low, df, dh, dr);
    n_cmp++; if (df !== 8'hC3) begin n_bad++; $display("FAIL io_ram_untouched: got %h want c3", df); end
  endtask

  task automatic test_reset_mid();
    int low; logic [7:0] v, df, dh, dr;
    @(negedge clock);
    ADD = 16'h0010; IO_Mn = 1'b0; rdn[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ready[1] !== 1'b0) break;
    end
    @(negedge clock);
    n_cmp++; if (d1 !== 8'hA5) begin n_bad++; $display("FAIL hold_data: got %h want a5", d1); end
    reset_in = 1'b1;
    @(negedge clock);
    n_cmp++; if (ready[1] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", ready[1]); end
    probe(1, v);
    n_cmp++; if (v !== Probe) begin n_bad++; $display("FAIL rst_mid_data: got %h want %h", v, Probe); end
    reset_in = 1'b0; rdn[1] = 1'b1;
    @(negedge clock);
    n_cmp++; if (iop0 !== 8'h00) begin n_bad++; $display("FAIL rst_io_port: got %h want 00", iop0); end
    rd(1, 16'h0010, 1'b0, 16'h0010, low, df, dh, dr);
    n_cmp++; if (low !== 3) begin n_bad++; $display("FAIL rst_read_ready_low: got %0d want 3", low); end
    n_cmp++; if (df !== 8'hA5) begin n_bad++; $display("FAIL rst_ram_kept: got %h want a5", df); end
  endtask

  task automatic test_back_to_back();
    int low; logic [7:0] df, dh, dr;
    wr(0, 16'h03FF, 8'h42, 1'b0, low);
    wr(0, 16'h0000, 8'h24, 1'b0, low);
    rd(0, 16'h03FF, 1'b0, 16'h03FF, low, df, dh, dr);
    n_cmp++; if (df !== 8'h42) begin n_bad++; $display("FAIL b2b_top: got %h want 42", df); end
    rd(0, 16'h0000, 1'b0, 16'h0000, low, df, dh, dr);
    n_cmp++; if (df !== 8'h24) begin n_bad++; $display("FAIL b2b_bottom: got %h want 24", df); end
  endtask

  initial begin
    reset_in = 1'b1; ADD = 16'h0000; IO_Mn = 1'b0;
    rdn = 3'b111; wrn = 3'b111; drv_en = 3'b000; drv_val = 8'h00;
    repeat (3) @(negedge clock);
    test_reset();
    reset_in = 1'b0;
    test_zero_wait();
    test_wait3();
    test_miss();
    test_abort();
    test_io();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
